// File: rtl/sa_skew_feeder_if.sv
// sa_skew_feeder_if
//   Bundles the upstream operand handshake, job control and array-edge drive
//   of the systolic-array skew feeder into one interface.
//   master : upstream job/operand source (drives START, K_LEN, IN_*).
//   slave  : the feeder itself (drives IN_READY, ARR_*, BUSY, DONE).
//   START     job start pulse
//   K_LEN     reduction length, sampled with START
//   IN_VALID  operand vector valid
//   IN_READY  feeder accepts operands this cycle
//   IN_A/IN_B N-lane operand vectors, lane i = bits [i*DW +: DW]
//   ARR_EN    enable to every PE
//   ARR_CLR   accumulator clear to every PE
//   ARR_A     west-edge A lanes, ARR_B north-edge B lanes
//   BUSY      job in progress, DONE one-cycle completion pulse
interface sa_skew_feeder_if #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int KW = 9
);
  logic            START;
  logic [KW-1:0]   K_LEN;
  logic            IN_VALID;
  logic            IN_READY;
  logic [N*DW-1:0] IN_A;
  logic [N*DW-1:0] IN_B;
  logic            ARR_EN;
  logic            ARR_CLR;
  logic [N*DW-1:0] ARR_A;
  logic [N*DW-1:0] ARR_B;
  logic            BUSY;
  logic            DONE;

  modport master (
    output START, K_LEN, IN_VALID, IN_A, IN_B,
    input  IN_READY, ARR_EN, ARR_CLR, ARR_A, ARR_B, BUSY, DONE
  );

  modport slave (
    input  START, K_LEN, IN_VALID, IN_A, IN_B,
    output IN_READY, ARR_EN, ARR_CLR, ARR_A, ARR_B, BUSY, DONE
  );
endinterface

// File: rtl/sa_skew_feeder.sv
// sa_skew_feeder
//   Operand feeder for an N x N output-stationary systolic array. Each job
//   clears the PE accumulators for one cycle, accepts K operand vectors
//   (one A and one B vector per handshake), then flushes 2N zero steps so
//   every product has reached its PE, and finally pulses DONE.
//   Lane i of each edge is delayed by i array steps (diagonal skew) through
//   a chain of i+1 registers that only advance when ARR_EN is high, so
//   stalls freeze the whole array and skew consistently.
// Ports
//   CLK  rising-edge clock
//   RST  asynchronous active-low reset
//   bus  sa_skew_feeder_if slave modport (handshake, control, array edges)
module sa_skew_feeder #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int KW = 9
) (
  input  logic             CLK,
  input  logic             RST,
  sa_skew_feeder_if.slave  bus
);

  localparam int FW = $clog2(2 * N);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * N - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_FLUSH,
    ST_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [KW-1:0]   k_reg;
  logic [KW-1:0]   feed_cnt;
  logic [FW-1:0]   flush_cnt;

  logic            in_ready;
  logic            accept;
  logic            flushing;
  logic            arr_en;
  logic            arr_clr;
  logic            busy;
  logic            done;
  logic            feed_last;
  logic            flush_last;

  logic [N*DW-1:0] arr_a;
  logic [N*DW-1:0] arr_b;

  // k_reg is never 0 while in FEED, so k_reg-1 does not underflow there.
  assign feed_last  = (feed_cnt == (k_reg - KW'(1)));
  assign flush_last = (flush_cnt == FLUSH_LAST);

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.START) begin
          state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        state_nxt = (k_reg != '0) ? ST_FEED : ST_FLUSH;
      end
      ST_FEED: begin
        if (accept && feed_last) begin
          state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (flush_last) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode. Everything except ARR_EN depends on state alone; ARR_EN
  // also follows IN_VALID so an idle upstream stalls the array in FEED.
  always_comb begin
    in_ready = 1'b0;
    flushing = 1'b0;
    arr_clr  = 1'b0;
    done     = 1'b0;
    busy     = 1'b1;
    case (state)
      ST_IDLE:  busy     = 1'b0;
      ST_CLEAR: arr_clr  = 1'b1;
      ST_FEED:  in_ready = 1'b1;
      ST_FLUSH: flushing = 1'b1;
      ST_DONE:  done     = 1'b1;
      default:  busy     = 1'b0;
    endcase
    accept = in_ready & bus.IN_VALID;
    arr_en = accept | flushing;
  end

  // Job counters. K_LEN is captured only when START is honoured, so later
  // changes on K_LEN have no effect on a running job.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      k_reg     <= '0;
      feed_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      if ((state == ST_IDLE) && bus.START) begin
        k_reg <= bus.K_LEN;
      end

      if (state == ST_CLEAR) begin
        feed_cnt <= '0;
      end else if (accept) begin
        feed_cnt <= feed_cnt + KW'(1);
      end

      if (state == ST_FLUSH) begin
        flush_cnt <= flush_cnt + FW'(1);
      end else begin
        flush_cnt <= '0;
      end
    end
  end

  // Skew chains: lane g holds g+1 stages. The chain input is the operand
  // lane on an accepted handshake and zero during FLUSH (the only other
  // time ARR_EN is high). CLEAR wipes the chains so stale data from an
  // aborted job can never reach the array.
  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [DW-1:0] a_chain [0:g];
    logic [DW-1:0] b_chain [0:g];
    logic [DW-1:0] a_in;
    logic [DW-1:0] b_in;

    assign a_in = accept ? bus.IN_A[g*DW +: DW] : '0;
    assign b_in = accept ? bus.IN_B[g*DW +: DW] : '0;

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        for (int s = 0; s <= g; s++) begin
          a_chain[s] <= '0;
          b_chain[s] <= '0;
        end
      end else if (arr_clr) begin
        for (int s = 0; s <= g; s++) begin
          a_chain[s] <= '0;
          b_chain[s] <= '0;
        end
      end else if (arr_en) begin
        a_chain[0] <= a_in;
        b_chain[0] <= b_in;
        for (int s = 1; s <= g; s++) begin
          a_chain[s] <= a_chain[s-1];
          b_chain[s] <= b_chain[s-1];
        end
      end
    end

    assign arr_a[g*DW +: DW] = a_chain[g];
    assign arr_b[g*DW +: DW] = b_chain[g];
  end

  assign bus.IN_READY = in_ready;
  assign bus.ARR_EN   = arr_en;
  assign bus.ARR_CLR  = arr_clr;
  assign bus.ARR_A    = arr_a;
  assign bus.ARR_B    = arr_b;
  assign bus.BUSY     = busy;
  assign bus.DONE     = done;

endmodule

// File: tb/tb_sa_skew_feeder.sv
// tb_sa_skew_feeder
//   Bench for sa_skew_feeder. A behavioural output-stationary PE array is
//   attached to the ARR_* edge so each job's accumulator matrix can be
//   compared against hand-computed results. The stimulus pushes the expected
//   job outcome (latency, ready cycles, C matrix) and expected skewed edge
//   values into queues; a monitor pops and compares on DONE / ARR_EN.
module tb_sa_skew_feeder;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int KW = 9;
  localparam int NN = N * N;

  typedef struct packed {
    int                   lat;
    int                   ready;
    logic [NN-1:0][31:0]  c;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  always #5 CLK = ~CLK;

  sa_skew_feeder_if #(.N(N), .DW(DW), .KW(KW)) bus ();

  sa_skew_feeder #(.N(N), .DW(DW), .KW(KW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  exp_t                 done_q [$];
  logic [2*N*DW-1:0]    skew_q [$];

  int n_cmp  = 0;
  int n_fail = 0;

  logic [N*DW-1:0] va [0:7];
  logic [N*DW-1:0] vb [0:7];
  int              t_job4 [NN];
  int              t_job6 [NN];

  // Shared comparison routine; every check in the bench goes through here.
  task automatic check_output(input string name, input longint got, input longint want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  function automatic logic [N*DW-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
    return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction

  // Monitor and PE array model. Inputs only change 1 time unit after a
  // rising edge, so values seen at the falling edge are exactly what the
  // next rising edge will capture.
  int                pa [N][N];
  int                pb [N][N];
  int                pc [N][N];
  bit                in_job;
  bit                busy_ok;
  int                lat;
  int                ready_cnt;
  bit                prev_en;
  bit                prev_clr;
  bit                prev_busy;
  logic [N*DW-1:0]   prev_a;
  logic [N*DW-1:0]   prev_b;
  logic [2*N*DW-1:0] skew_e;
  exp_t              job_e;

  always @(negedge CLK) begin
    if (!RST) begin
      in_job    = 1'b0;
      prev_en   = 1'b0;
      prev_clr  = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (prev_en && (skew_q.size() > 0)) begin
        skew_e = skew_q.pop_front();
        check_output("skew_arr_a", bus.ARR_A, skew_e[N*DW-1:0]);
        check_output("skew_arr_b", bus.ARR_B, skew_e[2*N*DW-1:N*DW]);
      end

      if (!prev_en && !prev_clr && prev_busy) begin
        check_output("stall_freeze_a", bus.ARR_A, prev_a);
        check_output("stall_freeze_b", bus.ARR_B, prev_b);
      end

      if (bus.ARR_CLR) begin
        in_job    = 1'b1;
        lat       = 0;
        ready_cnt = 0;
        busy_ok   = 1'b1;
      end else if (in_job) begin
        lat++;
      end
      if (in_job) begin
        if (!bus.BUSY) busy_ok = 1'b0;
        if (bus.IN_READY) ready_cnt++;
      end

      if (bus.DONE) begin
        check_output("done_expected", (done_q.size() > 0), 1);
        if (done_q.size() > 0) begin
          job_e = done_q.pop_front();
          check_output("job_latency", lat, job_e.lat);
          check_output("ready_cycles", ready_cnt, job_e.ready);
          check_output("busy_through_job", busy_ok, 1);
          for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
              check_output($sformatf("acc_c%0d%0d", r, c), pc[r][c], job_e.c[r*N+c]);
            end
          end
        end
        in_job = 1'b0;
      end

      // PE array: descending loops keep neighbour values from the old step.
      if (bus.ARR_EN) begin
        for (int r = N - 1; r >= 0; r--) begin
          for (int c = N - 1; c >= 0; c--) begin
            pc[r][c] = pc[r][c] + pa[r][c] * pb[r][c];
            pa[r][c] = (c == 0) ? int'(bus.ARR_A[r*DW +: DW]) : pa[r][c-1];
            pb[r][c] = (r == 0) ? int'(bus.ARR_B[c*DW +: DW]) : pb[r-1][c];
          end
        end
      end else if (bus.ARR_CLR) begin
        for (int r = 0; r < N; r++) begin
          for (int c = 0; c < N; c++) begin
            pa[r][c] = 0;
            pb[r][c] = 0;
            pc[r][c] = 0;
          end
        end
      end

      prev_en   = bus.ARR_EN;
      prev_clr  = bus.ARR_CLR;
      prev_busy = bus.BUSY;
      prev_a    = bus.ARR_A;
      prev_b    = bus.ARR_B;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Runs one job from va/vb. With stall set, IN_VALID is low for one FEED
  // cycle before every vector.
  task automatic apply_stimulus(input int k, input bit stall, input exp_t e);
    int guard;
    done_q.push_back(e);
    bus.START = 1'b1;
    bus.K_LEN = KW'(k);
    step();
    bus.START = 1'b0;
    bus.K_LEN = '1;
    for (int v = 0; v < k; v++) begin
      if (stall) begin
        bus.IN_VALID = 1'b0;
      end else begin
        bus.IN_VALID = 1'b1;
        bus.IN_A     = va[v];
        bus.IN_B     = vb[v];
      end
      guard = 0;
      while (!bus.IN_READY && (guard < 50)) begin
        step();
        guard++;
      end
      if (!bus.IN_READY) begin
        check_output("ready_timeout", bus.IN_READY, 1);
      end
      if (stall) begin
        step();
        bus.IN_VALID = 1'b1;
        bus.IN_A     = va[v];
        bus.IN_B     = vb[v];
      end
      step();
    end
    bus.IN_VALID = 1'b0;
    bus.IN_A     = '0;
    bus.IN_B     = '0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (bus.BUSY && (guard < 200)) begin
      step();
      guard++;
    end
    check_output("job_finished", bus.BUSY, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_busy"}, bus.BUSY, 0);
    check_output({tag, "_done"}, bus.DONE, 0);
    check_output({tag, "_in_ready"}, bus.IN_READY, 0);
    check_output({tag, "_arr_en"}, bus.ARR_EN, 0);
    check_output({tag, "_arr_clr"}, bus.ARR_CLR, 0);
    check_output({tag, "_arr_a"}, bus.ARR_A, 0);
    check_output({tag, "_arr_b"}, bus.ARR_B, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not reach the end");
    $fatal(1, "[TB] aborted");
  end

  initial begin
    exp_t e;
    int   busy_seen;
    logic [N*DW-1:0] sa;
    logic [N*DW-1:0] sb;

    bus.START    = 1'b0;
    bus.K_LEN    = '0;
    bus.IN_VALID = 1'b0;
    bus.IN_A     = '0;
    bus.IN_B     = '0;

    // Job-2 products of the back-to-back test and the post-reset job.
    t_job4 = '{7, 2, 4, 5,  5, 1, 5, 4,  3, 0, 6, 3,  13, 3, 11, 10};
    t_job6 = '{3, 4, 3, 8,  1, 2, 3, 4,  2, 3, 3, 6,  1, 2, 3, 4};

    #12;
    check_all_zero("reset");
    step();
    RST = 1'b1;
    step();

    // Test 1: K=1, A lanes 1..4, B all ones; C(r,c) = r+1.
    for (int ed = 1; ed <= 9; ed++) begin
      sa = '0;
      sb = '0;
      for (int i = 0; i < N; i++) begin
        if (ed == i + 1) begin
          sa[i*DW +: DW] = DW'(i + 1);
          sb[i*DW +: DW] = DW'(1);
        end
      end
      skew_q.push_back({sb, sa});
    end
    e = '0;
    e.lat = 10;
    e.ready = 1;
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) e.c[r*N+c] = 32'(r + 1);
    va[0] = pack4(1, 2, 3, 4);
    vb[0] = pack4(1, 1, 1, 1);
    apply_stimulus(1, 1'b0, e);
    wait_idle();
    step();

    // Test 2/3: identity rows, K=4, without and with alternate stalls.
    for (int k = 0; k < 4; k++) begin
      va[k] = '0;
      va[k][k*DW +: DW] = DW'(1);
      vb[k] = va[k];
    end
    e = '0;
    e.lat = 13;
    e.ready = 4;
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) e.c[r*N+c] = (r == c) ? 32'd1 : 32'd0;
    apply_stimulus(4, 1'b0, e);
    wait_idle();
    e.lat = 17;
    e.ready = 8;
    apply_stimulus(4, 1'b1, e);
    wait_idle();

    // Test 4: back-to-back jobs, all-255 K=3 then small values K=2.
    for (int k = 0; k < 3; k++) begin
      va[k] = '1;
      vb[k] = '1;
    end
    e = '0;
    e.lat = 12;
    e.ready = 3;
    for (int i = 0; i < NN; i++) e.c[i] = 32'd195075;
    apply_stimulus(3, 1'b0, e);
    wait_idle();
    va[0] = pack4(1, 2, 3, 4);
    vb[0] = pack4(1, 0, 2, 1);
    va[1] = pack4(2, 1, 0, 3);
    vb[1] = pack4(3, 1, 1, 2);
    e = '0;
    e.lat = 11;
    e.ready = 2;
    for (int i = 0; i < NN; i++) e.c[i] = 32'(t_job4[i]);
    apply_stimulus(2, 1'b0, e);
    wait_idle();

    // Test 5: K=0, with a START pulse while busy that must be ignored.
    e = '0;
    e.lat = 9;
    e.ready = 0;
    apply_stimulus(0, 1'b0, e);
    step();
    step();
    step();
    bus.START = 1'b1;
    bus.K_LEN = KW'(5);
    step();
    bus.START = 1'b0;
    wait_idle();
    busy_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.BUSY) busy_seen++;
    end
    check_output("no_second_job", busy_seen, 0);

    // Test 6: reset in the middle of FEED, then a clean K=2 job.
    bus.START = 1'b1;
    bus.K_LEN = KW'(4);
    step();
    bus.START    = 1'b0;
    bus.IN_VALID = 1'b1;
    bus.IN_A     = '1;
    bus.IN_B     = '1;
    step();
    step();
    step();
    #2;
    check_output("pre_reset_arr_en", bus.ARR_EN, 1);
    RST = 1'b0;
    #1;
    check_all_zero("async_reset");
    bus.IN_VALID = 1'b0;
    bus.IN_A     = '0;
    bus.IN_B     = '0;
    step();
    step();
    RST = 1'b1;
    step();
    va[0] = pack4(1, 1, 1, 1);
    vb[0] = pack4(1, 2, 3, 4);
    va[1] = pack4(2, 0, 1, 0);
    vb[1] = pack4(1, 1, 0, 2);
    e = '0;
    e.lat = 11;
    e.ready = 2;
    for (int i = 0; i < NN; i++) e.c[i] = 32'(t_job6[i]);
    apply_stimulus(2, 1'b0, e);
    wait_idle();

    step();
    step();
    check_output("done_queue_empty", done_q.size(), 0);
    check_output("skew_queue_empty", skew_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
